// File: rtl/corebootstrap_spi_arbiter_pkg.sv
// Shared definitions for the SPI flash arbiter: FSM state encoding,
// owner codes and a counter-width helper.
package corebootstrap_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_BOOT   = 3'd1;
    localparam logic [2:0] ST_HOST   = 3'd2;
    localparam logic [2:0] ST_G_B2H  = 3'd3;
    localparam logic [2:0] ST_G_H2B  = 3'd4;
    localparam logic [2:0] ST_G_IDLE = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_BOOT   = ST_BOOT,
        S_HOST   = ST_HOST,
        S_G_B2H  = ST_G_B2H,
        S_G_H2B  = ST_G_H2B,
        S_G_IDLE = ST_G_IDLE
    } state_e;

    localparam logic [1:0] OWN_NONE  = 2'b00;
    localparam logic [1:0] OWN_BOOT  = 2'b01;
    localparam logic [1:0] OWN_HOST  = 2'b10;
    localparam logic [1:0] OWN_GUARD = 2'b11;

    // Width needed to hold 0..max, never below one bit.
    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/corebootstrap_spi_arbiter_if.sv
// Request/grant bundle between the flash users and the arbiter.
// slave: arbiter side; master: boot engine / host / mux side.
interface corebootstrap_spi_arbiter_if;

    logic       boot_req;
    logic       boot_done;
    logic       boot_ss;
    logic       host_req;
    logic       HOST_SS;
    logic       boot_gnt;
    logic       host_gnt;
    logic       sel_host;
    logic       PROC_SYS_RESETN;
    logic [1:0] owner;

    modport slave (
        input  boot_req, boot_done, boot_ss, host_req, HOST_SS,
        output boot_gnt, host_gnt, sel_host, PROC_SYS_RESETN, owner
    );

    modport master (
        output boot_req, boot_done, boot_ss, host_req, HOST_SS,
        input  boot_gnt, host_gnt, sel_host, PROC_SYS_RESETN, owner
    );

endinterface

// File: rtl/corebootstrap_spi_arbiter_sync.sv
// N-stage flop synchroniser with a selectable reset value.
// Ports: clk, rst_n (async low), d_i (async in), q_o (synchronised out).
module corebootstrap_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {N{RST_VAL}};
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < N; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/corebootstrap_spi_arbiter.sv
// Shared SPI flash owner: boot engine vs host CPU, with guard gaps,
// host reset hold-off. Ports: HCLK, HRESETN, arb_if (slave modport).
module corebootstrap_spi_arbiter
    import corebootstrap_pkg::*;
#(
    parameter int GUARD_CYCLES = 4,
    parameter int RST_DELAY    = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                         HCLK,
    input  logic                         HRESETN,
    corebootstrap_spi_arbiter_if.slave   arb_if
);

    localparam int GW = cnt_w(GUARD_CYCLES);
    localparam int RW = cnt_w(RST_DELAY);
    localparam logic [GW-1:0] G_MAX = GW'(GUARD_CYCLES);
    localparam logic [RW-1:0] R_MAX = RW'(RST_DELAY);

    logic host_req_s;
    logic host_ss_s;

    corebootstrap_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_req (
        .clk   (HCLK),
        .rst_n (HRESETN),
        .d_i   (arb_if.host_req),
        .q_o   (host_req_s)
    );

    corebootstrap_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk   (HCLK),
        .rst_n (HRESETN),
        .d_i   (arb_if.HOST_SS),
        .q_o   (host_ss_s)
    );

    state_e          state_q, state_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic [RW-1:0]   rcnt_q, rcnt_d;
    logic            bc_q, bc_d;
    logic            done_q, done_d;
    logic            rel_q, rel_d;
    logic            bgnt_q, bgnt_d;
    logic            hgnt_q, hgnt_d;
    logic            sel_q, sel_d;
    logic [1:0]      own_q, own_d;

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q <= S_IDLE;
            gcnt_q  <= '0;
            rcnt_q  <= '0;
            bc_q    <= 1'b0;
            done_q  <= 1'b0;
            rel_q   <= 1'b0;
            bgnt_q  <= 1'b0;
            hgnt_q  <= 1'b0;
            sel_q   <= 1'b0;
            own_q   <= OWN_NONE;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            rcnt_q  <= rcnt_d;
            bc_q    <= bc_d;
            done_q  <= done_d;
            rel_q   <= rel_d;
            bgnt_q  <= bgnt_d;
            hgnt_q  <= hgnt_d;
            sel_q   <= sel_d;
            own_q   <= own_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gcnt_d  = '0;
        bc_d    = bc_q | ((state_q == S_BOOT) & arb_if.boot_done);
        // done_q remembers a boot_done seen during the current BOOT tenure
        done_d  = (state_q == S_BOOT) & (done_q | arb_if.boot_done);

        unique case (state_q)
            S_IDLE: begin
                if (arb_if.boot_req)
                    state_d = S_BOOT;
                else if (host_req_s && bc_q)
                    state_d = S_G_IDLE;
            end
            S_BOOT: begin
                if (arb_if.boot_ss &&
                    (done_q || arb_if.boot_done || !arb_if.boot_req))
                    state_d = S_G_B2H;
            end
            S_HOST: begin
                if (host_ss_s && (!host_req_s || arb_if.boot_req))
                    state_d = S_G_H2B;
            end
            S_G_B2H, S_G_H2B, S_G_IDLE: begin
                // Destination is re-decided at guard exit, boot first
                if (gcnt_q == G_MAX) begin
                    if (arb_if.boot_req)
                        state_d = S_BOOT;
                    else if (host_req_s && bc_q)
                        state_d = S_HOST;
                    else
                        state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rcnt_d = (bc_q && rcnt_q != R_MAX) ? rcnt_q + 1'b1 : rcnt_q;
        rel_d  = rel_q | (bc_d && rcnt_d == R_MAX);

        bgnt_d = (state_d == S_BOOT);
        hgnt_d = (state_d == S_HOST);
        // Mux select only moves when a grant is being (re)issued
        sel_d  = (state_d == S_HOST) ? 1'b1 :
                 (state_d == S_BOOT) ? 1'b0 : sel_q;

        unique case (state_d)
            S_IDLE:  own_d = OWN_NONE;
            S_BOOT:  own_d = OWN_BOOT;
            S_HOST:  own_d = OWN_HOST;
            default: own_d = OWN_GUARD;
        endcase
    end

    assign arb_if.boot_gnt        = bgnt_q;
    assign arb_if.host_gnt        = hgnt_q;
    assign arb_if.sel_host        = sel_q;
    assign arb_if.PROC_SYS_RESETN = rel_q;
    assign arb_if.owner           = own_q;

endmodule

// File: tb/tb_corebootstrap_spi_arbiter.sv
// Directed bench for corebootstrap_spi_arbiter with an expectation queue.
// Output vector compared: {boot_gnt, host_gnt, sel_host, PROC_SYS_RESETN, owner}.
module tb_corebootstrap_spi_arbiter;

    typedef struct {
        string      tag;
        logic [5:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic HCLK    = 1'b0;
    logic HRESETN = 1'b0;

    always #5 HCLK = ~HCLK;

    corebootstrap_spi_arbiter_if bus ();

    corebootstrap_spi_arbiter #(
        .GUARD_CYCLES (4),
        .RST_DELAY    (16),
        .SYNC_STAGES  (2)
    ) dut (
        .HCLK    (HCLK),
        .HRESETN (HRESETN),
        .arb_if  (bus)
    );

    logic [5:0] obs;
    assign obs = {bus.boot_gnt, bus.host_gnt, bus.sel_host,
                  bus.PROC_SYS_RESETN, bus.owner};

    function automatic logic [5:0] mk(input logic bg, input logic hg,
                                      input logic sel, input logic rn,
                                      input logic [1:0] own);
        return {bg, hg, sel, rn, own};
    endfunction

    task automatic expect_out(input string tag, input logic [5:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic compare();
        exp_t x;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty: observed %b with no expectation", obs);
        end else begin
            x = sb.pop_front();
            assert (obs === x.exp) else begin
                errors++;
                $error("FAIL %s: observed %b expected %b", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic step(input string tag, input logic [5:0] e);
        expect_out(tag, e);
        tick();
        compare();
    endtask

    // Continuous invariants, sampled on the falling edge
    logic sel_prev = 1'b0;
    logic bg_prev  = 1'b0;
    logic hg_prev  = 1'b0;

    always @(negedge HCLK) begin
        if (HRESETN) begin
            checks++;
            assert (!(bus.boot_gnt && bus.host_gnt)) else begin
                errors++;
                $error("FAIL both_gnt: observed bg=%b hg=%b expected not both",
                       bus.boot_gnt, bus.host_gnt);
            end
            if (bus.sel_host !== sel_prev) begin
                checks++;
                assert (!bg_prev && !hg_prev) else begin
                    errors++;
                    $error("FAIL sel_glitch: observed prev bg=%b hg=%b expected 0 0",
                           bg_prev, hg_prev);
                end
            end
        end
        sel_prev = bus.sel_host;
        bg_prev  = bus.boot_gnt;
        hg_prev  = bus.host_gnt;
    end

    localparam logic [5:0] IDLE0 = 6'b000000;
    localparam logic [5:0] BOOT0 = 6'b100001;
    localparam logic [5:0] BOOT1 = 6'b100101;
    localparam logic [5:0] G000  = 6'b000011;
    localparam logic [5:0] G001  = 6'b000111;
    localparam logic [5:0] G011  = 6'b001111;
    localparam logic [5:0] HOST0 = 6'b011010;
    localparam logic [5:0] HOST1 = 6'b011110;

    initial begin
        bus.boot_req  = 1'b0;
        bus.boot_done = 1'b0;
        bus.boot_ss   = 1'b1;
        bus.host_req  = 1'b0;
        bus.HOST_SS   = 1'b1;

        repeat (3) tick();
        expect_out("reset_state", IDLE0);
        compare();
        HRESETN = 1'b1;

        // Host asks before any boot: must be ignored
        bus.host_req = 1'b1;
        for (int i = 0; i < 12; i++) step("host_before_boot", IDLE0);

        // Power-up boot with host waiting
        bus.boot_req = 1'b1;
        step("boot_grant", BOOT0);
        bus.boot_ss = 1'b0;
        for (int i = 0; i < 4; i++) step("boot_frame", BOOT0);
        bus.boot_ss = 1'b1;
        step("boot_ss_idle_no_done", BOOT0);
        bus.boot_done = 1'b1;
        bus.boot_req  = 1'b0;
        step("b2h_guard_entry", G000);
        bus.boot_done = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            if (k < 5)
                step("b2h_guard", G000);
            else if (k < 16)
                step("handover_host", HOST0);
            else
                step("resetn_release", HOST1);
        end

        // Preemption is held off while host frame active
        bus.HOST_SS = 1'b0;
        for (int i = 0; i < 3; i++) step("host_frame", HOST1);
        bus.boot_req = 1'b1;
        for (int i = 0; i < 4; i++) step("no_preempt_mid_frame", HOST1);
        bus.HOST_SS = 1'b1;
        for (int i = 0; i < 2; i++) step("preempt_sync_delay", HOST1);
        for (int i = 0; i < 5; i++) step("h2b_guard", G011);
        step("preempt_boot_gnt", BOOT1);

        // boot_done arrives while boot frame still active
        bus.boot_ss = 1'b0;
        step("boot2_frame", BOOT1);
        bus.boot_done = 1'b1;
        step("late_done_pulse", BOOT1);
        bus.boot_done = 1'b0;
        for (int i = 0; i < 10; i++) step("late_done_hold", BOOT1);
        bus.boot_ss = 1'b1;
        step("late_guard_start", G001);
        bus.boot_req = 1'b0;
        for (int i = 0; i < 4; i++) step("late_guard", G001);
        step("late_to_host", HOST1);

        // Asynchronous reset in the middle of a host tenure
        #2;
        HRESETN = 1'b0;
        #1;
        expect_out("async_reset", IDLE0);
        compare();
        tick();
        tick();
        HRESETN = 1'b1;
        for (int i = 0; i < 8; i++) step("post_reset_host_ignored", IDLE0);
        bus.boot_req = 1'b1;
        step("reboot_grant", BOOT0);
        bus.boot_req  = 1'b0;
        bus.boot_done = 1'b1;
        step("reboot_guard_entry", G000);
        bus.boot_done = 1'b0;
        for (int i = 0; i < 4; i++) step("reboot_guard", G000);
        step("reboot_host", HOST0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
